// File: rtl/mem_types_pkg.sv
// rtl/mem_types_pkg.sv - shared memory-side types, constants and adaptor state encoding
package mem_types_pkg;

    localparam int BEATS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = 5;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  burst_t;
    typedef logic [31:0]  addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - beat counter with clear, increment and last-beat flag
module burst_beat_counter #(
    parameter int NUM_BEATS = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             is_last
);

    // Saturates on the last beat so the count never leaves 0..NUM_BEATS-1;
    // only an explicit clear brings it back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (incr && !is_last) begin
            count <= count + 1'b1;
        end
    end

    assign is_last = (count == CNT_W'(NUM_BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - splits/assembles one cache line into memory bursts
module cacheline_burst_adaptor
    import mem_types_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int NUM_BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    adaptor_state_t        state_q;
    adaptor_state_t        state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wr_line_q;
    logic [LINE_WIDTH-1:0] rd_line_q;
    logic [CNT_W-1:0]      count;
    logic                  is_last;
    logic                  cnt_clear;
    logic                  cnt_incr;
    logic                  take_write;
    logic                  take_read;

    burst_beat_counter #(
        .NUM_BEATS (NUM_BEATS),
        .CNT_W     (CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .incr    (cnt_incr),
        .count   (count),
        .is_last (is_last)
    );

    // State register; reset aborts any burst in flight without a completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; write wins when both requests are high.
    always_comb begin
        state_d    = state_q;
        cnt_clear  = 1'b0;
        cnt_incr   = 1'b0;
        take_write = 1'b0;
        take_read  = 1'b0;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    take_write = 1'b1;
                    cnt_clear  = 1'b1;
                    state_d    = ST_WRITE;
                end else if (read_i) begin
                    take_read = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                read_o = 1'b1;
                if (resp_i) begin
                    cnt_incr = 1'b1;
                    if (is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                write_o = 1'b1;
                if (resp_i) begin
                    cnt_incr = 1'b1;
                    if (is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                resp_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latching and read-beat assembly; read and write lines are kept
    // apart so a write never disturbs the last assembled read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
        end else begin
            if (take_write) begin
                wr_line_q <= line_i;
                addr_q    <= address_i;
            end
            if (take_read) begin
                addr_q <= address_i;
            end
            if (state_q == ST_READ && resp_i) begin
                rd_line_q[int'(count)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            end
        end
    end

    assign address_o = {addr_q[ADDR_WIDTH-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
    assign burst_o   = (state_q == ST_WRITE) ? wr_line_q[int'(count)*BURST_WIDTH +: BURST_WIDTH]
                                             : '0;
    assign line_o    = rd_line_q;

endmodule
